// File: rtl/mandelbrot_iterator_array.sv
// Frame-level Mandelbrot engine: raster dispatcher, NUM_ITER z=z^2+c slots, round-robin collector.
// Build option CARDIOID_SKIP_EN: pixels in the main cardioid or period-2 bulb finish without iterating.
module mandelbrot_iterator_array #(
  parameter int NUM_ITER = 25,
  parameter int WIDTH    = 27,
  parameter int FRAC     = 23,
  parameter int X_RES    = 640,
  parameter int Y_RES    = 480,
  parameter int ITER_W   = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ITER_W-1:0] max_iter,
  input  logic [WIDTH-1:0]  cr_top_left,
  input  logic [WIDTH-1:0]  ci_top_left,
  input  logic [WIDTH-1:0]  cr_incr,
  input  logic [WIDTH-1:0]  ci_incr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [9:0]        out_x,
  output logic [9:0]        out_y,
  output logic [ITER_W-1:0] out_count,
  output logic              busy,
  output logic              done,
  output logic [31:0]       cycles
);
  // state  | meaning
  // S_IDLE | slot free, may accept the next pixel
  // S_RUN  | iterating one z=z^2+c step per cycle
  // S_DONE | result held until the collector grants it
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} slot_state_t;

  localparam int PW    = 2 * WIDTH;
  localparam int PTR_W = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;
  localparam logic signed [WIDTH-1:0] TWO     = WIDTH'(64'sd2 <<< FRAC);
  localparam logic signed [PW:0]      FOUR_SQ = (PW+1)'(64'sd4 <<< (2 * FRAC));

  slot_state_t              st   [NUM_ITER];
  logic signed [WIDTH-1:0]  zr   [NUM_ITER];
  logic signed [WIDTH-1:0]  zi   [NUM_ITER];
  logic signed [WIDTH-1:0]  cr_s [NUM_ITER];
  logic signed [WIDTH-1:0]  ci_s [NUM_ITER];
  logic [ITER_W-1:0]        k    [NUM_ITER];
  logic [9:0]               px   [NUM_ITER];
  logic [9:0]               py   [NUM_ITER];

  logic signed [WIDTH-1:0]  nzr  [NUM_ITER];
  logic signed [WIDTH-1:0]  nzi  [NUM_ITER];
  logic                     esc  [NUM_ITER];
  logic [ITER_W-1:0]        kn   [NUM_ITER];

  logic [ITER_W-1:0]        max_it;
  logic signed [WIDTH-1:0]  cr_row, cr_cur, ci_cur, cr_step, ci_step;
  logic [9:0]               disp_x, disp_y;
  logic                     disp_done;
  logic [PTR_W-1:0]         rr_ptr, free_idx, gnt_idx;
  logic                     free_found, gnt_found, gnt_en, all_idle, frame_end, skip;

  function automatic logic signed [WIDTH-1:0] fx_mul(input logic signed [WIDTH-1:0] a,
                                                     input logic signed [WIDTH-1:0] b,
                                                     input logic dbl);
    logic signed [PW-1:0] p;
    p = PW'(a) * PW'(b);
    if (dbl) p = p <<< 1;
    return p[FRAC+WIDTH-1:FRAC];
  endfunction

  // Magnitude test uses the untruncated squares so values just above 2.0 are not lost.
  function automatic logic escaped(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b);
    logic signed [PW-1:0] aa, bb;
    logic signed [PW:0]   mag;
    aa  = PW'(a) * PW'(a);
    bb  = PW'(b) * PW'(b);
    mag = (PW+1)'(aa) + (PW+1)'(bb);
    return (a > TWO) || (a < -TWO) || (b > TWO) || (b < -TWO) || (mag > FOUR_SQ);
  endfunction

`ifdef CARDIOID_SKIP_EN
  localparam logic signed [WIDTH-1:0] ONE       = WIDTH'(64'sd1 <<< FRAC);
  localparam logic signed [WIDTH-1:0] QUARTER   = WIDTH'(64'sd1 <<< (FRAC - 2));
  localparam logic signed [WIDTH-1:0] SIXTEENTH = WIDTH'(64'sd1 <<< (FRAC - 4));

  function automatic logic in_set(input logic signed [WIDTH-1:0] a,
                                  input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] am, ap, ii, q;
    am = a - QUARTER;
    ap = a + ONE;
    ii = fx_mul(b, b, 1'b0);
    q  = fx_mul(am, am, 1'b0) + ii;
    return (fx_mul(q, q + am, 1'b0) <= (ii >>> 2)) ||
           ((fx_mul(ap, ap, 1'b0) + ii) <= SIXTEENTH);
  endfunction

  assign skip = in_set(cr_cur, ci_cur);
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < NUM_ITER; i++) begin
      nzr[i] = fx_mul(zr[i], zr[i], 1'b0) - fx_mul(zi[i], zi[i], 1'b0) + cr_s[i];
      nzi[i] = fx_mul(zr[i], zi[i], 1'b1) + ci_s[i];
      esc[i] = escaped(nzr[i], nzi[i]);
      kn[i]  = k[i] + 1'b1;
    end
  end

  // Lowest free slot for dispatch; first DONE slot at or after rr_ptr for collection.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    gnt_found  = 1'b0;
    gnt_idx    = '0;
    all_idle   = 1'b1;
    for (int i = NUM_ITER - 1; i >= 0; i--) begin
      if (st[i] == S_IDLE) begin
        free_found = 1'b1;
        free_idx   = PTR_W'(i);
      end else begin
        all_idle = 1'b0;
      end
      if (st[(int'(rr_ptr) + i) % NUM_ITER] == S_DONE) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_W'((int'(rr_ptr) + i) % NUM_ITER);
      end
    end
    gnt_en    = gnt_found && (!out_valid || out_ready);
    frame_end = disp_done && all_idle && out_valid && out_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      cycles    <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_count <= '0;
      rr_ptr    <= '0;
      max_it    <= ITER_W'(1);
      cr_row    <= '0;
      cr_cur    <= '0;
      ci_cur    <= '0;
      cr_step   <= '0;
      ci_step   <= '0;
      disp_x    <= '0;
      disp_y    <= '0;
      disp_done <= 1'b0;
      for (int i = 0; i < NUM_ITER; i++) begin
        st[i]   <= S_IDLE;
        zr[i]   <= '0;
        zi[i]   <= '0;
        cr_s[i] <= '0;
        ci_s[i] <= '0;
        k[i]    <= '0;
        px[i]   <= '0;
        py[i]   <= '0;
      end
    end else if (start && !busy) begin
      busy      <= 1'b1;
      done      <= 1'b0;
      cycles    <= '0;
      rr_ptr    <= '0;
      max_it    <= (max_iter == '0) ? ITER_W'(1) : max_iter;
      cr_row    <= cr_top_left;
      cr_cur    <= cr_top_left;
      ci_cur    <= ci_top_left;
      cr_step   <= cr_incr;
      ci_step   <= ci_incr;
      disp_x    <= '0;
      disp_y    <= '0;
      disp_done <= 1'b0;
    end else if (busy) begin
      if (cycles != 32'hFFFF_FFFF) cycles <= cycles + 1'b1;

      for (int i = 0; i < NUM_ITER; i++) begin
        if (st[i] == S_RUN) begin
          k[i]  <= kn[i];
          zr[i] <= nzr[i];
          zi[i] <= nzi[i];
          if (esc[i] || kn[i] == max_it) st[i] <= S_DONE;
        end
      end

      if (!disp_done && free_found) begin
        st[free_idx]   <= skip ? S_DONE : S_RUN;
        zr[free_idx]   <= '0;
        zi[free_idx]   <= '0;
        k[free_idx]    <= skip ? max_it : '0;
        cr_s[free_idx] <= cr_cur;
        ci_s[free_idx] <= ci_cur;
        px[free_idx]   <= disp_x;
        py[free_idx]   <= disp_y;
        if (disp_x == 10'(X_RES - 1)) begin
          disp_x <= '0;
          cr_cur <= cr_row;
          ci_cur <= ci_cur - ci_step;
          if (disp_y == 10'(Y_RES - 1)) disp_done <= 1'b1;
          else disp_y <= disp_y + 1'b1;
        end else begin
          disp_x <= disp_x + 1'b1;
          cr_cur <= cr_cur + cr_step;
        end
      end

      if (gnt_en) begin
        out_valid    <= 1'b1;
        out_x        <= px[gnt_idx];
        out_y        <= py[gnt_idx];
        out_count    <= k[gnt_idx];
        st[gnt_idx]  <= S_IDLE;
        rr_ptr       <= (gnt_idx == PTR_W'(NUM_ITER - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (frame_end) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mandelbrot_iterator_array.sv
// Scoreboard bench for mandelbrot_iterator_array on a 4x4 frame with 3 slots.
module tb_mandelbrot_iterator_array;
  localparam int NI = 3, W = 27, FR = 23, XR = 4, YR = 4, IW = 11;
  localparam longint ONE    = longint'(1) <<< FR;
  localparam longint TWO    = 2 * ONE;
  localparam longint FOURSQ = 4 * ONE * ONE;
  localparam int BUDGET = 20000;

  logic clk = 1'b0;
  logic reset, start, out_valid, out_ready, busy, done;
  logic [IW-1:0] max_iter, out_count;
  logic [W-1:0]  cr_top_left, ci_top_left, cr_incr, ci_incr;
  logic [9:0]    out_x, out_y;
  logic [31:0]   cycles;

  int n_pass = 0;
  int n_checks = 0;
  int n_frame;

  typedef struct {int x; int y; int cnt;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mandelbrot_iterator_array #(
    .NUM_ITER(NI), .WIDTH(W), .FRAC(FR), .X_RES(XR), .Y_RES(YR), .ITER_W(IW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .max_iter(max_iter),
    .cr_top_left(cr_top_left), .ci_top_left(ci_top_left),
    .cr_incr(cr_incr), .ci_incr(ci_incr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_count(out_count),
    .busy(busy), .done(done), .cycles(cycles)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int model_count(input longint cr, input longint ci, input int mi);
    longint zr = 0, zi = 0, nr, ni;
    int m = (mi == 0) ? 1 : mi;
    for (int k = 1; k <= m; k++) begin
      nr = ((zr * zr) >>> FR) - ((zi * zi) >>> FR) + cr;
      ni = ((2 * zr * zi) >>> FR) + ci;
      if (nr > TWO || nr < -TWO || ni > TWO || ni < -TWO || (nr * nr + ni * ni) > FOURSQ) return k;
      if (k == m) return k;
      zr = nr;
      zi = ni;
    end
    return m;
  endfunction

  // mode 0: always ready; 1: random ready plus a 50-cycle stall; 2: ready, extra start while busy
  task automatic run_frame(input string tag, input longint crt, input longint cit,
                           input longint cri, input longint cii, input int mi,
                           input int mode, output int n);
    int got, viol, found, stall_left;
    logic hold;
    logic [9:0] hx, hy;
    logic [IW-1:0] hc;
    sb.delete();
    for (int y = 0; y < YR; y++)
      for (int x = 0; x < XR; x++)
        sb.push_back('{x, y, model_count(crt + x * cri, cit - y * cii, mi)});
    @(negedge clk);
    cr_top_left = W'(crt);
    ci_top_left = W'(cit);
    cr_incr     = W'(cri);
    ci_incr     = W'(cii);
    max_iter    = IW'(mi);
    out_ready   = 1'b1;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_at_start"}, busy, 1);
    chk({tag, "_done_cleared"}, done, 0);
    n = 0; got = 0; viol = 0; hold = 1'b0; stall_left = 0;
    hx = '0; hy = '0; hc = '0;
    while (1) begin
      if (mode == 1 && n == 40) stall_left = 50;
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else if (mode == 1) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = 1'b1;
      if (mode == 2 && n == 10) begin
        start = 1'b1;
        max_iter = IW'(5);
        cr_top_left = '0;
      end
      @(negedge clk);
      if (hold && (!out_valid || out_x != hx || out_y != hy || out_count != hc)) viol++;
      hold = out_valid && !out_ready;
      hx = out_x; hy = out_y; hc = out_count;
      if (out_valid && out_ready) begin
        found = 0;
        for (int i = 0; i < sb.size(); i++) begin
          if (sb[i].x == int'(out_x) && sb[i].y == int'(out_y)) begin
            chk({tag, "_count"}, out_count, sb[i].cnt);
            sb.delete(i);
            found = 1;
            break;
          end
        end
        chk({tag, "_xy_expected"}, found, 1);
        got++;
      end
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (done || n >= BUDGET) break;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_valid_after_done"}, out_valid, 0);
    chk({tag, "_results"}, got, XR * YR);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    chk({tag, "_cycles"}, cycles, n);
    if (mode == 1) chk({tag, "_stall_stable"}, viol, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; max_iter = '0;
    cr_top_left = '0; ci_top_left = '0; cr_incr = '0; ci_incr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_out_x", out_x, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_count", out_count, 0);
    reset = 1'b0;

    // c=0 everywhere: every pixel runs to the cap
    run_frame("f1", 0, 0, 0, 0, 1000, 0, n_frame);
    chk("f1_cycles_range", (n_frame >= 6000 && n_frame <= 6100), 1);

    // real axis -2..1 (c=-2 never escapes, c=1 escapes after 3)
    run_frame("f2", -2 * ONE, 0, ONE, ONE / 4, 50, 0, n_frame);
    run_frame("f3", -3 * ONE / 2, ONE, 3 * ONE / 4, ONE / 2, 200, 1, n_frame);
    // real axis -1..2 (c=2 escapes after 2)
    run_frame("f4", -ONE, 0, ONE, ONE / 8, 30, 0, n_frame);

    run_frame("f5", -2 * ONE, 0, ONE, ONE / 4, 0, 0, n_frame);
    repeat (30) @(posedge clk);
    #1;
    chk("f5_done_held", done, 1);
    chk("f5_busy_idle", busy, 0);
    chk("f5_cycles_frozen", cycles, n_frame);

    run_frame("f6", -2 * ONE, 0, ONE, ONE / 4, 50, 2, n_frame);

    // abort a frame with a result waiting on the output
    @(negedge clk);
    cr_top_left = W'(-ONE); ci_top_left = '0; cr_incr = W'(ONE); ci_incr = W'(ONE / 8);
    max_iter = IW'(1000); out_ready = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("abort_pending_valid", out_valid, 1);
    chk("abort_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy_cleared", busy, 0);
    chk("abort_valid_cleared", out_valid, 0);
    chk("abort_done_cleared", done, 0);
    chk("abort_cycles_cleared", cycles, 0);

    run_frame("f7", -ONE, 0, ONE, ONE / 8, 30, 0, n_frame);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
